// File: rtl/cpu_pkg.sv
// Shared types and defaults for the 9-bit CPU control path.
// Sequencer state encoding, PC-select encoding and the HALT opcode live here.
package cpu_pkg;

    localparam int PC_WIDTH    = 10;
    localparam int INSTR_WIDTH = 9;
    localparam int MEM_TIMEOUT = 15;

    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } seq_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_ZERO,
        PC_INC,
        PC_BRANCH
    } pc_sel_t;

endpackage

// File: rtl/cpu_sequencer_pc_unit.sv
// Program counter register with its next-PC mux.
// The sequencer picks hold / zero / +1 / branch target each cycle.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int pc_width = PC_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  pc_sel_t             sel_i,
    input  logic [pc_width-1:0] target_i,
    output logic [pc_width-1:0] pc_o
);

    logic [pc_width-1:0] pc_q;
    logic [pc_width-1:0] pc_d;

    // +1 is truncated to pc_width, so the top address wraps to 0.
    always_comb begin
        pc_d = pc_q;
        unique case (sel_i)
            PC_ZERO:   pc_d = '0;
            PC_INC:    pc_d = pc_q + 1'b1;
            PC_BRANCH: pc_d = target_i;
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/exec/mem/writeback sequencer for the 9-bit CPU.
// Optional PERF_COUNT_EN adds cycle_count / instr_count performance counters.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int pc_width    = PC_WIDTH,
    parameter int instr_width = INSTR_WIDTH,
    parameter int mem_timeout = MEM_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [instr_width-1:0] instr_rdata,
    input  logic                   dec_reg_write,
    input  logic                   dec_mem_read,
    input  logic                   dec_mem_write,
    input  logic                   dec_branch,
    input  logic                   dec_halt,
    input  logic                   branch_cond,
    input  logic [pc_width-1:0]    branch_target,
    input  logic                   mem_ack,
    output logic [pc_width-1:0]    instr_addr,
    output logic [instr_width-1:0] ir,
    output logic                   rf_we,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic                   busy,
    output logic                   done,
`ifdef PERF_COUNT_EN
    output logic                   fault,
    output logic [31:0]            cycle_count,
    output logic [31:0]            instr_count
`else
    output logic                   fault
`endif
);

    localparam int                CNT_W    = $clog2(mem_timeout + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(mem_timeout - 1);

    seq_state_t             state_q;
    logic [instr_width-1:0] ir_q;
    logic                   fault_q;
    logic [CNT_W-1:0]       wait_q;

    logic    idle_like;
    logic    start_ok;
    pc_sel_t pc_sel;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALTED);
    assign start_ok  = start && idle_like;

    always_comb begin
        pc_sel = PC_HOLD;
        if (start_ok)
            pc_sel = PC_ZERO;
        else if (state_q == S_WB)
            pc_sel = (dec_branch && branch_cond) ? PC_BRANCH : PC_INC;
    end

    pc_unit #(
        .pc_width (pc_width)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .sel_i    (pc_sel),
        .target_i (branch_target),
        .pc_o     (instr_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            fault_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        fault_q <= 1'b0;
                    end
                end
                S_FETCH: state_q <= S_LOAD;
                S_LOAD: begin
                    ir_q    <= instr_rdata;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    wait_q <= '0;
                    if (dec_halt)
                        state_q <= S_HALTED;
                    else if (dec_mem_read || dec_mem_write)
                        state_q <= S_MEM;
                    else
                        state_q <= S_WB;
                end
                // An ack on the final allowed cycle still completes normally.
                S_MEM: begin
                    if (mem_ack) begin
                        state_q <= S_WB;
                    end else if (wait_q == CNT_LAST) begin
                        fault_q <= 1'b1;
                        state_q <= S_HALTED;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ir      = ir_q;
    assign rf_we   = (state_q == S_WB) && dec_reg_write && !dec_mem_write;
    assign mem_req = (state_q == S_MEM);
    assign mem_we  = (state_q == S_MEM) && dec_mem_write;
    assign busy    = !idle_like;
    assign done    = (state_q == S_HALTED);
    assign fault   = fault_q;

`ifdef PERF_COUNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instr_q;

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (busy)             cycle_q <= cycle_q + 32'd1;
            if (state_q == S_WB)  instr_q <= instr_q + 32'd1;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle expected outputs are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [8:0] instr_rdata;
    logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_halt;
    logic       branch_cond;
    logic [9:0] branch_target;
    logic       mem_ack;
    logic [9:0] instr_addr;
    logic [8:0] ir;
    logic       rf_we, mem_req, mem_we, busy, done, fault;
`ifdef PERF_COUNT_EN
    logic [31:0] cycle_count, instr_count;
`endif

    cpu_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .instr_rdata   (instr_rdata),
        .dec_reg_write (dec_reg_write),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_branch    (dec_branch),
        .dec_halt      (dec_halt),
        .branch_cond   (branch_cond),
        .branch_target (branch_target),
        .mem_ack       (mem_ack),
        .instr_addr    (instr_addr),
        .ir            (ir),
        .rf_we         (rf_we),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .busy          (busy),
        .done          (done),
`ifdef PERF_COUNT_EN
        .fault         (fault),
        .cycle_count   (cycle_count),
        .instr_count   (instr_count)
`else
        .fault         (fault)
`endif
    );

    always #5 clk = ~clk;

    // Opcodes of the toy decoder used here (top 3 bits of ir)
    localparam logic [8:0] I_ADD  = 9'b001_000000;
    localparam logic [8:0] I_LW   = 9'b010_000000;
    localparam logic [8:0] I_SW   = 9'b011_000000;
    localparam logic [8:0] I_BR   = 9'b100_000000;
    localparam logic [8:0] I_HALT = 9'b111_000000;

    // flags = {rf_we, mem_req, mem_we, busy, done, fault}
    localparam logic [5:0] IDL = 6'b000000;
    localparam logic [5:0] BSY = 6'b000100;
    localparam logic [5:0] WBW = 6'b100100;
    localparam logic [5:0] MRQ = 6'b010100;
    localparam logic [5:0] MWR = 6'b011100;
    localparam logic [5:0] HLT = 6'b000010;
    localparam logic [5:0] FLT = 6'b000011;

    logic [8:0] rom [0:1023];
    always @(posedge clk) instr_rdata <= rom[instr_addr];

    logic [2:0] op;
    assign op            = ir[8:6];
    assign dec_reg_write = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
    assign dec_mem_read  = (op == 3'd2);
    assign dec_mem_write = (op == 3'd3);
    assign dec_branch    = (op == 3'd4);
    assign dec_halt      = (op == 3'd7);

    // Memory responder: ack after ack_delay low cycles of a request.
    int ack_delay = 0;
    int ack_cnt   = 0;
    always @(posedge clk) ack_cnt <= mem_req ? ack_cnt + 1 : 0;
    assign mem_ack = mem_req && (ack_cnt == ack_delay);

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    exp_t        mon_e;
    logic [15:0] mon_got;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {instr_addr, rf_we, mem_req, mem_we, busy, done, fault};
            n_vec++;
            if (mon_got !== mon_e.v) begin
                n_bad++;
                $display("FAIL %s: got addr=%h flags=%b, expected addr=%h flags=%b",
                         mon_e.tag, mon_got[15:6], mon_got[5:0], mon_e.v[15:6], mon_e.v[5:0]);
            end
        end
    end

    task automatic step(input string tag, input logic [9:0] a, input logic [5:0] f,
                        input logic st);
        exp_t e;
        e.tag = tag;
        e.v   = {a, f};
        start = st;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic fetch3(input string tag, input logic [9:0] a);
        step({tag, ".fetch"}, a, BSY, 1'b0);
        step({tag, ".load"},  a, BSY, 1'b0);
        step({tag, ".exec"},  a, BSY, 1'b0);
    endtask

    task automatic run_alu(input string tag, input logic [9:0] a, input logic rf);
        fetch3(tag, a);
        step({tag, ".wb"}, a, rf ? WBW : BSY, 1'b0);
    endtask

    task automatic run_mem(input string tag, input logic [9:0] a, input logic we, input int n);
        fetch3(tag, a);
        for (int i = 0; i <= n; i++) step({tag, ".mem"}, a, we ? MWR : MRQ, 1'b0);
        step({tag, ".wb"}, a, we ? BSY : WBW, 1'b0);
    endtask

    task automatic run_halt(input string tag, input logic [9:0] a);
        fetch3(tag, a);
        step({tag, ".halted"}, a, HLT, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = I_HALT;
        reset = 1'b1; start = 1'b0;
        branch_cond = 1'b0; branch_target = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ADD then HALT from reset; a start during LOAD must be ignored
        rom[0] = I_ADD; rom[1] = I_HALT;
        step("reset", 10'd0, IDL, 1'b0);
        step("start", 10'd0, IDL, 1'b1);
        step("add.fetch", 10'd0, BSY, 1'b0);
        step("add.load",  10'd0, BSY, 1'b1);
        step("add.exec",  10'd0, BSY, 1'b0);
        step("add.wb",    10'd0, WBW, 1'b0);
        run_halt("halt1", 10'd1);
        step("halt1.hold", 10'd1, HLT, 1'b0);

        // LW with ack after 3 wait cycles
        rom[0] = I_LW; ack_delay = 3;
        step("lw.start", 10'd1, HLT, 1'b1);
        run_mem("lw", 10'd0, 1'b0, 3);
        run_halt("lw.h", 10'd1);

        // SW with immediate ack: no register write
        rom[0] = I_SW; ack_delay = 0;
        step("sw.start", 10'd1, HLT, 1'b1);
        run_mem("sw", 10'd0, 1'b1, 0);
        run_halt("sw.h", 10'd1);

        // Ack on the 15th MEM cycle beats the timeout
        rom[0] = I_LW; ack_delay = 14;
        step("ack15.start", 10'd1, HLT, 1'b1);
        run_mem("ack15", 10'd0, 1'b0, 14);
        run_halt("ack15.h", 10'd1);

        // Ack never arrives: fault after 15 MEM cycles, then restart clears it
        ack_delay = 1000;
        step("to.start", 10'd1, HLT, 1'b1);
        fetch3("to", 10'd0);
        for (int i = 0; i < 15; i++) step("to.mem", 10'd0, MRQ, 1'b0);
        step("to.fault", 10'd0, FLT, 1'b0);
        step("to.hold",  10'd0, FLT, 1'b0);
        ack_delay = 0;
        step("to.restart", 10'd0, FLT, 1'b1);
        run_mem("to.re", 10'd0, 1'b0, 0);
        run_halt("to.re.h", 10'd1);

        // Branch taken at PC 5 to 0x020
        rom[0] = I_BR; rom[5] = I_BR; rom[6] = I_HALT; rom[10'h020] = I_HALT;
        branch_cond = 1'b1; branch_target = 10'd5;
        step("bt.start", 10'd1, HLT, 1'b1);
        run_alu("bt.pc0", 10'd0, 1'b0);
        branch_target = 10'h020;
        run_alu("bt.pc5", 10'd5, 1'b0);
        run_halt("bt.h", 10'h020);

        // Branch not taken at PC 5 falls through to 6
        branch_target = 10'd5;
        step("bn.start", 10'h020, HLT, 1'b1);
        run_alu("bn.pc0", 10'd0, 1'b0);
        branch_cond = 1'b0; branch_target = 10'h020;
        run_alu("bn.pc5", 10'd5, 1'b0);
        run_halt("bn.h", 10'd6);

        // PC 0x3FF non-branch wraps to 0
        rom[1] = I_HALT; rom[10'h3FF] = I_ADD;
        branch_cond = 1'b1; branch_target = 10'h3FF;
        step("wrap.start", 10'd6, HLT, 1'b1);
        run_alu("wrap.pc0", 10'd0, 1'b0);
        run_alu("wrap.top", 10'h3FF, 1'b1);
        branch_cond = 1'b0;
        run_alu("wrap.pc0b", 10'd0, 1'b0);
        run_halt("wrap.h", 10'd1);

        // Reset during MEM drops mem_req and returns to IDLE
        rom[0] = I_LW; ack_delay = 1000;
        step("rm.start", 10'd1, HLT, 1'b1);
        fetch3("rm", 10'd0);
        step("rm.mem0", 10'd0, MRQ, 1'b0);
        step("rm.mem1", 10'd0, MRQ, 1'b0);
        reset = 1'b1;
        step("rm.mem2", 10'd0, MRQ, 1'b0);
        reset = 1'b0;
        step("rm.idle",  10'd0, IDL, 1'b0);
        step("rm.idle2", 10'd0, IDL, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
